stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits.
REQ-002 Parameter DEPTH, 8, number of stack entries; power of two, 2 to 256.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 push  input  1  write selected data onto the stack this cycle.
REQ-006 pop  input  1  remove the top entry and load it into dout.
REQ-007 tos  input  1  load the top entry into dout without removing it.
REQ-008 mtos  input  1  push source select: 1 = mem_data, 0 = alu_data.
REQ-009 mem_data  input  WIDTH  memory read data, push source when mtos=1.
REQ-010 alu_data  input  WIDTH  ALU result, push source when mtos=0.
REQ-011 dout  output  WIDTH  registered data output (popped or peeked word).
REQ-012 count  output  clog2(DEPTH)+1  current number of valid entries.
REQ-013 empty  output  1  count == 0, combinational from count.
REQ-014 full  output  1  count == DEPTH, combinational from count.
REQ-015 ovf  output  1  sticky overflow flag (STACK_ERR_EN only; constant 0 otherwise).
REQ-016 unf  output  1  sticky underflow flag (STACK_ERR_EN only; constant 0 otherwise).

Function
REQ-017 Storage: DEPTH x WIDTH register array; entry index count-1 is the top.
REQ-018 Push data: din = mtos ? mem_data : alu_data, sampled at the same edge.
REQ-019 push only, not full: array[count] <= din, count <= count+1, dout unchanged.
REQ-020 push only, full: no write, count unchanged, dout unchanged; overflow event.
REQ-021 pop only, not empty: dout <= array[count-1], count <= count-1, single-cycle latency (valid the cycle after the edge).
REQ-022 pop only, empty: count and dout unchanged; underflow event.
REQ-023 tos (without pop), not empty: dout <= array[count-1], count unchanged.
REQ-024 tos (without pop), empty: dout unchanged; underflow event.
REQ-025 pop and tos both asserted: treated as pop; tos ignored.
REQ-026 push and pop together, not empty: dout <= old top, array[count-1] <= din, count unchanged (replace-top).
REQ-027 push and pop together, empty: push only is performed (count becomes 1, dout unchanged); underflow event.
REQ-028 push and tos together (no pop), not empty: dout <= old top, then push per REQ-019/020.
REQ-029 No inputs asserted: all state holds.
REQ-030 Entries above the top are don't-care; they are never read out.

Reset
REQ-031 When rst=1 at a rising edge: count <= 0, dout <= 0, ovf <= 0, unf <= 0; all other inputs are ignored that cycle.
REQ-032 Reset mid-sequence discards all entries; array contents need not be cleared.
REQ-033 First operation is accepted at the first edge with rst=0.

Configuration
REQ-034 Macro STACK_ERR_EN: when defined, ovf sets on any overflow event and unf on any underflow event, both held until rst.
REQ-035 Without STACK_ERR_EN: ovf and unf are tied to 0, no flag registers exist; all other behaviour is identical.

Verification
REQ-036 Reset, then push 0x11,0x22,0x33 (mtos=0 via alu_data) -> count=3; pop three times -> dout 0x33,0x22,0x11; empty=1.
REQ-037 Push 0xA5 with mtos=1 (mem_data=0xA5, alu_data=0x5A); tos -> dout=0xA5, count=1.
REQ-038 Push DEPTH words, then push 0xFF -> full=1, count=DEPTH, top unchanged; ovf=1 with STACK_ERR_EN, 0 without.
REQ-039 On empty stack assert pop -> dout holds previous value, count=0; unf=1 with STACK_ERR_EN; then rst -> unf=0, dout=0.
REQ-040 Stack [0x01,0x02]; push+pop with alu_data=0x07 -> dout=0x02, count=2; next pop -> dout=0x07.
REQ-041 Push 0x10,0x20, assert rst with push=1 -> count=0, empty=1, dout=0; next pop -> underflow, dout=0.

Source files
------------

// File: rtl/stack_unit.sv
// -----------------------------------------------------------------------------
// stack_unit -- LIFO operand stack with a registered read port.
//
// This stack holds DEPTH words of WIDTH bits. Entry count-1 is the top. A push
// writes the selected source word, which is mem_data when mtos=1 and alu_data
// otherwise. A pop or a peek (tos) copies the top entry into the registered
// dout on the same edge, so the word is visible in the cycle after that edge.
//
// Optional feature: define STACK_ERR_EN to build the sticky overflow and
// underflow flags. In the default build, ovf and unf are tied to 0 and no
// flag registers exist.
//
// Ports
//   clk       in   clock; every state change happens on the rising edge
//   rst       in   synchronous, active-high reset
//   push      in   push the selected source word
//   pop       in   remove the top entry and load it into dout
//   tos       in   load the top entry into dout without removing it
//   mtos      in   push source select: 1 = mem_data, 0 = alu_data
//   mem_data  in   [WIDTH-1:0] memory read data
//   alu_data  in   [WIDTH-1:0] ALU result
//   dout      out  [WIDTH-1:0] registered popped or peeked word
//   count     out  [clog2(DEPTH):0] number of valid entries
//   empty     out  count == 0
//   full      out  count == DEPTH
//   ovf       out  sticky overflow flag (STACK_ERR_EN only)
//   unf       out  sticky underflow flag (STACK_ERR_EN only)
//
// Command semantics: push, pop and tos are single-cycle strobes. There is no
// handshake. Each strobe is sampled on the rising edge where it is high, and
// the stack never back-pressures. A command that cannot complete is dropped.
// Such commands are a push when full, or a pop or peek when empty, and each
// one raises the matching error event. When pop and tos are both high, the
// command is a pop. When push and pop are both high on a non-empty stack, the
// top entry is replaced and dout receives the old top.
// -----------------------------------------------------------------------------
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   tos,
  input  logic                   mtos,
  input  logic [WIDTH-1:0]       mem_data,
  input  logic [WIDTH-1:0]       alu_data,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   ovf,
  output logic                   unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [WIDTH-1:0] din;
  logic [AW-1:0]    top_idx;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [CW-1:0]    cnt_nxt;
  logic             dout_ld;

  assign din     = mtos ? mem_data : alu_data;
  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  // This value is only used when the stack is not empty, so the wrap that
  // happens at count == 0 does no harm.
  assign top_idx = AW'(count - CW'(1));

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = count[AW-1:0];
    cnt_nxt = count;
    dout_ld = 1'b0;
    if (pop) begin
      if (!empty) begin
        dout_ld = 1'b1;
        if (push) begin
          // Replace the top: the old top goes to dout, and the new word
          // takes its slot.
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end else begin
          cnt_nxt = count - CW'(1);
        end
      end else if (push) begin
        // A pop on an empty stack is dropped, but the push still goes ahead.
        wr_en   = 1'b1;
        wr_idx  = '0;
        cnt_nxt = CW'(1);
      end
    end else begin
      if (tos && !empty) dout_ld = 1'b1;
      if (push && !full) begin
        wr_en   = 1'b1;
        wr_idx  = count[AW-1:0];
        cnt_nxt = count + CW'(1);
      end
    end
  end

  // The storage array has no reset. Entries above the top are never read.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      dout  <= '0;
    end else begin
      count <= cnt_nxt;
      if (dout_ld) dout <= mem[top_idx];
    end
  end

`ifdef STACK_ERR_EN
  logic ovf_ev;
  logic unf_ev;

  assign ovf_ev = push && !pop && full;
  assign unf_ev = (pop || tos) && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_ev) ovf <= 1'b1;
      if (unf_ev) unf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// -----------------------------------------------------------------------------
// tb_stack_unit -- directed testbench for stack_unit with a scoreboard.
//
// The driver applies one command per clock. After each edge it queues the
// expected {dout, count, empty, full, ovf, unf} record for that command,
// together with a name for it. The monitor takes one record off the queue on
// each falling edge and compares it against the outputs of the design.
// -----------------------------------------------------------------------------
module tb_stack_unit;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int EW    = WIDTH + CW + 4;

`ifdef STACK_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             push = 1'b0, pop = 1'b0, tos = 1'b0, mtos = 1'b0;
  logic [WIDTH-1:0] mem_data = '0, alu_data = '0;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
  logic             empty, full, ovf, unf;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .mtos(mtos),
    .mem_data(mem_data), .alu_data(alu_data), .dout(dout), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            checks = 0;
  int            errors = 0;

  // These hold the flag values the current step expects. The sequence below
  // sets them by hand at each overflow, underflow and reset.
  logic exp_ovf = 1'b0;
  logic exp_unf = 1'b0;

  logic [EW-1:0] mon_exp;
  logic [EW-1:0] mon_act;
  string         mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_nm  = name_q.pop_front();
      mon_act = {dout, count, empty, full, ovf, unf};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b, expected dout=%h count=%0d empty=%b full=%b ovf=%b unf=%b",
                 mon_nm, dout, count, empty, full, ovf, unf,
                 mon_exp[EW-1 -: WIDTH], mon_exp[CW+3:4], mon_exp[3], mon_exp[2],
                 mon_exp[1], mon_exp[0]);
      end
    end
  end

  // ---------------- driver ----------------
  // The task drives one command for one clock edge and queues the expected
  // outputs. empty and full follow the expected count.
  task automatic step(input logic r, input logic p, input logic po,
                      input logic t, input logic m,
                      input logic [WIDTH-1:0] md, input logic [WIDTH-1:0] ad,
                      input logic [WIDTH-1:0] e_dout, input int e_cnt,
                      input string nm);
    logic [CW-1:0] ec;
    rst = r; push = p; pop = po; tos = t; mtos = m;
    mem_data = md; alu_data = ad;
    @(posedge clk);
    #1;
    ec = CW'(e_cnt);
    exp_q.push_back({e_dout, ec, (e_cnt == 0), (e_cnt == DEPTH), exp_ovf, exp_unf});
    name_q.push_back(nm);
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0; tos = 1'b0; mtos = 1'b0;
  endtask

  task automatic do_push(input logic [WIDTH-1:0] ad, input logic [WIDTH-1:0] e_dout,
                         input int e_cnt, input string nm);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ad, e_dout, e_cnt, nm);
  endtask

  task automatic do_pop(input logic [WIDTH-1:0] e_dout, input int e_cnt, input string nm);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, e_dout, e_cnt, nm);
  endtask

  task automatic do_rst(input string nm);
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 0, nm);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no end of stimulus, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_rst("reset_0");
    do_rst("reset_1");

    // Push three words from alu_data, then pop them back in reverse order.
    do_push(8'h11, 8'h00, 1, "push_11");
    do_push(8'h22, 8'h00, 2, "push_22");
    do_push(8'h33, 8'h00, 3, "push_33");
    do_pop(8'h33, 2, "pop_33");
    do_pop(8'h22, 1, "pop_22");
    do_pop(8'h11, 0, "pop_11_empty");

    // Push from mem_data (alu_data differs), then peek and pop.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 8'h5A, 8'h11, 1, "push_mem_a5");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hA5, 1, "tos_a5");
    do_pop(8'hA5, 0, "pop_a5");

    // Replace the top with a simultaneous push and pop.
    do_push(8'h01, 8'hA5, 1, "push_01");
    do_push(8'h02, 8'hA5, 2, "push_02");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h07, 8'h02, 2, "push_pop_replace");
    do_pop(8'h07, 1, "pop_07");
    do_pop(8'h01, 0, "pop_01");

    // Fill to DEPTH, then push once more to overflow.
    for (int i = 0; i < DEPTH; i++)
      do_push(8'h80 + 8'(i), 8'h01, i + 1, $sformatf("fill_%0d", i));
    exp_ovf = ERR;
    do_push(8'hFF, 8'h01, DEPTH, "push_full_ovf");
    do_pop(8'h87, DEPTH - 1, "pop_top_unchanged");

    // A push together with tos on a non-empty stack: dout gets the old top.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 8'h86, DEPTH, "push_tos");
    do_pop(8'h99, DEPTH - 1, "pop_99");
    // With pop and tos both high, the command is a pop.
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h86, DEPTH - 2, "pop_and_tos");

    // Underflow cases on an empty stack.
    do_rst("reset_clears_ovf");
    do_push(8'h3C, 8'h00, 1, "push_3c");
    do_pop(8'h3C, 0, "pop_3c");
    exp_unf = ERR;
    do_pop(8'h3C, 0, "pop_empty_unf");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h3C, 0, "tos_empty");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h44, 8'h3C, 1, "push_pop_empty");
    do_pop(8'h44, 0, "pop_44");
    do_rst("reset_clears_unf");

    // Reset in the middle of a sequence, with push also high during reset.
    do_push(8'h10, 8'h00, 1, "push_10");
    do_push(8'h20, 8'h00, 2, "push_20");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h55, 8'h00, 0, "reset_with_push");
    exp_unf = ERR;
    do_pop(8'h00, 0, "pop_after_reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 8'hDD, 8'h00, 0, "idle_hold");

    // Give the monitor a few cycles to take the remaining records off the
    // queue.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d records still queued, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
